openmips_commit_checker: RTL and testbench

Parametrised, self-checking commit monitor for OpenMIPS simulation benches. It replaces a fixed run-for-N-ns testbench with a pass/fail verdict. It observes the MEM/WB register write-back port of the core inside openmips_min_sopc and compares each commit, in order, against a preloaded table of expected (register, value) pairs. It detects stalls with a watchdog and reports done/pass/fail/timeout plus error counts, so benches can end on a verdict instead of a wall-clock stop.

---
 rtl/openmips_commit_checker.sv | 149 ++++++++++++++
 tb/tb_openmips_commit_checker.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openmips_commit_checker.sv
// In-order commit checker for OpenMIPS benches: compares MEM/WB write-backs against a
// preloaded (register, value) table and reports pass/fail/timeout with a stall watchdog.
module openmips_commit_checker #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned TO_W      = 11,
  parameter bit          IGNORE_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [REG_AW-1:0] exp_reg,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [IDX_W:0]    num_exp,
  input  logic              stop_on_fail,
  input  logic              start,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic              mismatch,
  output logic [IDX_W:0]    err_count,
  output logic [IDX_W:0]    commit_idx,
  output logic [IDX_W-1:0]  first_fail_idx
);

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTmo} state_e;

  localparam logic [TO_W-1:0] WdLast = TO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [IDX_W:0]     cidx_q, cidx_d;
  logic [IDX_W:0]     err_q, err_d;
  logic [IDX_W:0]     nexp_q, nexp_d;
  logic [IDX_W-1:0]   ffi_q, ffi_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               sof_q, sof_d;
  logic               mis_q, mis_d;

  logic [REG_AW-1:0]  tbl_reg  [DEPTH];
  logic [DATA_W-1:0]  tbl_data [DEPTH];

  logic               qual;
  logic               neq;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W:0]     cidx_inc;
  logic [IDX_W:0]     err_sat;

  // Table has no reset; it is only writable while idle so a run sees a stable image.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && exp_we) begin
      tbl_reg[exp_addr]  <= exp_reg;
      tbl_data[exp_addr] <= exp_data;
    end
  end

  assign qual     = wb_we && !(IGNORE_R0 && (wb_waddr == '0));
  assign rd_idx   = cidx_q[IDX_W-1:0];
  assign neq      = (wb_waddr != tbl_reg[rd_idx]) || (wb_wdata != tbl_data[rd_idx]);
  assign cidx_inc = cidx_q + 1'b1;
  assign err_sat  = (err_q == '1) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    err_d   = err_q;
    nexp_d  = nexp_q;
    ffi_d   = ffi_q;
    wd_d    = wd_q;
    sof_d   = sof_q;
    mis_d   = 1'b0;
    unique case (state_q)
      StIdle, StPass, StFail, StTmo: begin
        if (start) begin
          cidx_d  = '0;
          err_d   = '0;
          ffi_d   = '0;
          wd_d    = '0;
          nexp_d  = num_exp;
          sof_d   = stop_on_fail;
          state_d = (num_exp == '0) ? StPass : StRun;
        end
      end
      StRun: begin
        if (qual) begin
          mis_d  = neq;
          cidx_d = cidx_inc;
          wd_d   = '0;
          if (neq) begin
            err_d = err_sat;
            if (err_q == '0) ffi_d = rd_idx;
          end
          if (neq && sof_q) begin
            state_d = StFail;
          end else if (cidx_inc == nexp_q) begin
            state_d = (err_d == '0) ? StPass : StFail;
          end
        end else if (wd_q == WdLast) begin
          // A commit in the expiring cycle wins over the watchdog.
          state_d = StTmo;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cidx_q  <= '0;
      err_q   <= '0;
      nexp_q  <= '0;
      ffi_q   <= '0;
      wd_q    <= '0;
      sof_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
      err_q   <= err_d;
      nexp_q  <= nexp_d;
      ffi_q   <= ffi_d;
      wd_q    <= wd_d;
      sof_q   <= sof_d;
      mis_q   <= mis_d;
    end
  end

  assign busy           = (state_q == StRun);
  assign pass           = (state_q == StPass);
  assign fail           = (state_q == StFail);
  assign timeout        = (state_q == StTmo);
  assign done           = pass || fail || timeout;
  assign mismatch       = mis_q;
  assign err_count      = err_q;
  assign commit_idx     = cidx_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_openmips_commit_checker.sv
// Scoreboard bench for openmips_commit_checker: stimulus pushes predicted mismatch cycles and
// run verdicts into queues; a monitor pops them as the DUT pulses mismatch or raises done.
module tb_openmips_commit_checker;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_addr = '0;
  logic [4:0]  exp_reg = '0;
  logic [31:0] exp_data = '0;
  logic [4:0]  num_exp = '0;
  logic        stop_on_fail = 1'b0;
  logic        start = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        busy, done, pass, fail, timeout, mismatch;
  logic [4:0]  err_count, commit_idx;
  logic [3:0]  first_fail_idx;

  openmips_commit_checker #(
    .DATA_W(32), .REG_AW(5), .DEPTH(16), .IDX_W(4),
    .TIMEOUT(TIMEOUT), .TO_W(4), .IGNORE_R0(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .exp_we(exp_we), .exp_addr(exp_addr), .exp_reg(exp_reg),
    .exp_data(exp_data), .num_exp(num_exp), .stop_on_fail(stop_on_fail), .start(start),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .mismatch(mismatch), .err_count(err_count),
    .commit_idx(commit_idx), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic we; logic [4:0] addr; logic [31:0] data;
    logic xwe; logic [3:0] xaddr; logic [4:0] xreg; logic [31:0] xdata;
    logic st;
  } ent_t;
  typedef struct { int at; bit p; bit f; bit t; int errc; int cidx; int ffi; } verd_t;

  logic [4:0]  m_reg  [16];
  logic [31:0] m_data [16];
  ent_t  drv[$];
  int    mq[$];
  verd_t vq[$];
  verd_t last_v;
  int    nvec = 0;
  int    nerr = 0;
  logic  done_prev = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic ent_t mk(input logic we, input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    e.we = we; e.addr = a; e.data = d;
    e.xwe = 1'b0; e.xaddr = '0; e.xreg = '0; e.xdata = '0; e.st = 1'b0;
    return e;
  endfunction

  // Reference: walk the committed stream with the checker's rules, edge by edge.
  task automatic model(input int s, input int nexp, input bit sof, input bit want_v);
    verd_t v;
    int idx, err, ffi, last, e;
    bit run_on, q, mis;
    idx = 0; err = 0; ffi = 0; last = s + 1; run_on = 1'b1;
    v.p = 0; v.f = 0; v.t = 0; v.at = 0;
    if (nexp == 0) begin run_on = 1'b0; v.p = 1; v.at = s + 1; end
    for (int k = 0; k < drv.size() && run_on; k++) begin
      e = s + 2 + k;
      q = drv[k].we && (drv[k].addr != 0);
      if (q) begin
        mis = (drv[k].addr != m_reg[idx]) || (drv[k].data != m_data[idx]);
        if (mis) begin
          mq.push_back(e);
          if (err == 0) ffi = idx;
          err++;
        end
        idx++;
        last = e;
        if (mis && sof) begin run_on = 1'b0; v.f = 1; v.at = e; end
        else if (idx == nexp) begin run_on = 1'b0; v.p = (err == 0); v.f = (err != 0); v.at = e; end
      end else if (e - last == TIMEOUT) begin
        run_on = 1'b0; v.t = 1; v.at = e;
      end
    end
    if (run_on) begin v.t = 1; v.at = last + TIMEOUT; end
    v.errc = err; v.cidx = idx; v.ffi = ffi;
    last_v = v;
    if (want_v) vq.push_back(v);
  endtask

  initial begin : monitor
    verd_t v;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mismatch) begin
          if (mq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_mismatch: pulse seen at cycle %0d, required none", cyc);
          end else chk("mismatch_cycle", cyc, mq.pop_front());
        end
        if (done && !done_prev) begin
          if (vq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_done: done rose at cycle %0d, required no verdict", cyc);
          end else begin
            v = vq.pop_front();
            chk("verdict_cycle", cyc, v.at);
            chk("pass", int'(pass), int'(v.p));
            chk("fail", int'(fail), int'(v.f));
            chk("timeout", int'(timeout), int'(v.t));
            chk("err_count", int'(err_count), v.errc);
            chk("commit_idx", int'(commit_idx), v.cidx);
            if (v.f) chk("first_fail_idx", int'(first_fail_idx), v.ffi);
          end
        end
      end
      done_prev = done;
    end
  end

  task automatic apply(input ent_t e);
    start = e.st; wb_we = e.we; wb_waddr = e.addr; wb_wdata = e.data;
    exp_we = e.xwe; exp_addr = e.xaddr; exp_reg = e.xreg; exp_data = e.xdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(mk(1'b0, 5'd0, 32'd0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_commit_idx", int'(commit_idx), 0);
    chk("rst_ffi", int'(first_fail_idx), 0);
    rst = 1'b1;
  endtask

  task automatic load_tbl(input bit fixed);
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = 5'($urandom_range(1, 31));
      m_data[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
    end
    if (fixed) begin
      m_reg[0] = 5'd1; m_data[0] = 32'h1100;
      m_reg[1] = 5'd2; m_data[1] = 32'h0020;
      m_reg[2] = 5'd3; m_data[2] = 32'h1120;
      m_reg[3] = 5'd4; m_data[3] = 32'h1120;
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_we = 1'b1; exp_addr = 4'(i); exp_reg = m_reg[i]; exp_data = m_data[i];
    end
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  // Writes outside IDLE must not reach the table; the model is deliberately left untouched.
  task automatic junk_writes();
    repeat (3) begin
      @(negedge clk);
      exp_we = 1'b1; exp_addr = 4'($urandom_range(0, 15));
      exp_reg = 5'($urandom); exp_data = $urandom;
    end
    @(negedge clk);
    exp_we = 1'b0;
  endtask

  task automatic build_rand(input int nexp, input int pmis, input int plong, input int extra);
    ent_t e;
    int gap;
    drv.delete();
    for (int i = 0; i < nexp + extra; i++) begin
      if ($urandom_range(0, 99) < plong) gap = $urandom_range(6, 9);
      else gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      for (int g = 0; g < gap; g++) drv.push_back(mk(1'($urandom_range(0, 1)), 5'd0, $urandom));
      if (i < 16) e = mk(1'b1, m_reg[i], m_data[i]);
      else e = mk(1'b1, 5'($urandom_range(1, 31)), $urandom);
      if ($urandom_range(0, 99) < pmis) begin
        if ($urandom_range(0, 1) == 0) e.data = e.data ^ (32'd1 << $urandom_range(0, 31));
        else e.addr = (e.addr == 5'd31) ? 5'd1 : e.addr + 5'd1;
      end
      drv.push_back(e);
    end
    for (int k = 0; k < drv.size(); k++) begin
      drv[k].xwe = ($urandom_range(0, 7) == 0);
      drv[k].xaddr = 4'($urandom_range(0, 15));
      drv[k].xreg = 5'($urandom);
      drv[k].xdata = $urandom;
    end
    if (nexp > 0 && drv.size() > 0) drv[0].st = 1'($urandom_range(0, 1));
  endtask

  task automatic do_run(input int nexp, input bit sof, input bit want_v, input bit tail);
    int s;
    @(negedge clk);
    s = cyc;
    apply(mk(1'b0, 5'd0, 32'd0));
    start = 1'b1; num_exp = 5'(nexp); stop_on_fail = sof;
    model(s, nexp, sof, want_v);
    for (int k = 0; k < drv.size(); k++) begin
      @(negedge clk);
      apply(drv[k]);
    end
    @(negedge clk);
    apply(mk(1'b0, 5'd0, 32'd0));
    if (tail) begin
      repeat (TIMEOUT + 4) @(negedge clk);
      chk("hold_done", int'(done), 1);
      chk("hold_pass", int'(pass), int'(last_v.p));
      chk("hold_timeout", int'(timeout), int'(last_v.t));
      chk("hold_commit_idx", int'(commit_idx), last_v.cidx);
      chk("hold_err_count", int'(err_count), last_v.errc);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_time_limit: bench still running at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin : stim
    int nexp;
    bit rs;
    repeat (2) @(negedge clk);
    do_reset();
    load_tbl(1'b1);

    // All four commits match, back to back.
    drv.delete();
    drv.push_back(mk(1, 5'd1, 32'h1100)); drv.push_back(mk(1, 5'd2, 32'h0020));
    drv.push_back(mk(1, 5'd3, 32'h1120)); drv.push_back(mk(1, 5'd4, 32'h1120));
    do_run(4, 1'b0, 1'b1, 1'b1);

    // Third commit carries bad data; run continues to the end.
    junk_writes();
    drv[2] = mk(1, 5'd3, 32'h1121);
    do_run(4, 1'b0, 1'b1, 1'b1);

    // Second commit to the wrong register with stop_on_fail set.
    drv.delete();
    drv.push_back(mk(1, 5'd1, 32'h1100)); drv.push_back(mk(1, 5'd5, 32'h0020));
    drv.push_back(mk(1, 5'd3, 32'h1120)); drv.push_back(mk(1, 5'd4, 32'h1120));
    do_run(4, 1'b1, 1'b1, 1'b1);

    // One commit then silence: watchdog expiry.
    drv.delete();
    drv.push_back(mk(1, 5'd1, 32'h1100));
    do_run(2, 1'b0, 1'b1, 1'b1);

    // Commit lands on the last watchdog cycle and is accepted.
    for (int g = 0; g < TIMEOUT - 1; g++) drv.push_back(mk(0, 5'd2, 32'h0020));
    drv.push_back(mk(1, 5'd2, 32'h0020));
    do_run(2, 1'b0, 1'b1, 1'b1);

    // $0 writes interleaved are never checked.
    drv.delete();
    drv.push_back(mk(1, 5'd0, 32'hdead)); drv.push_back(mk(1, 5'd1, 32'h1100));
    drv.push_back(mk(1, 5'd0, 32'h1)); drv.push_back(mk(1, 5'd0, 32'h0020));
    drv.push_back(mk(1, 5'd2, 32'h0020));
    do_run(2, 1'b0, 1'b1, 1'b1);

    // Empty run from IDLE passes immediately.
    do_reset();
    load_tbl(1'b1);
    drv.delete();
    do_run(0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset mid-run, with table writes attempted during RUN.
    do_reset();
    load_tbl(1'b1);
    drv.delete();
    drv.push_back(mk(1, 5'd1, 32'h1100)); drv.push_back(mk(1, 5'd2, 32'h0021));
    drv.push_back(mk(0, 5'd0, 32'h0)); drv.push_back(mk(0, 5'd0, 32'h0));
    drv[2].xwe = 1'b1; drv[2].xaddr = 4'd2; drv[2].xreg = 5'd9; drv[2].xdata = 32'h55;
    do_run(4, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_err_count", int'(err_count), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_err_count", int'(err_count), 0);
    chk("async_rst_commit_idx", int'(commit_idx), 0);
    @(negedge clk);
    rst = 1'b1;
    // Table entry 2 must still hold $3=0x1120 after the ignored RUN write.
    drv.delete();
    drv.push_back(mk(1, 5'd1, 32'h1100)); drv.push_back(mk(1, 5'd2, 32'h0020));
    drv.push_back(mk(1, 5'd3, 32'h1120));
    do_run(3, 1'b0, 1'b1, 1'b1);

    for (int r = 0; r < 40; r++) begin
      rs = (r % 4 == 0) || ($urandom_range(0, 3) == 0);
      if (rs) begin do_reset(); load_tbl(1'b0); end
      else junk_writes();
      nexp = rs ? $urandom_range(0, 16) : $urandom_range(1, 16);
      build_rand(nexp, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 30),
                 $urandom_range(0, 12), $urandom_range(0, 2));
      do_run(nexp, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end

    repeat (2) @(negedge clk);
    chk("mismatch_queue_drained", mq.size(), 0);
    chk("verdict_queue_drained", vq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
